// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: FSM state types, SSD1306 command bytes and the init/sync command sequences.
package ssd1306_pkg;

    typedef enum logic [2:0] {S_RST_LOW, S_RST_WAIT, S_INIT, S_IDLE, S_DATA, S_SYNC} state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LOW, TX_HIGH, TX_HOLD, TX_GAP} tx_stage_t;

    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
    localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] CMD_START_LINE   = 8'h40;
    localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
    localparam logic [7:0] CMD_SEG_REMAP    = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_DEC = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
    localparam logic [7:0] CMD_CONTRAST     = 8'h81;
    localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
    localparam logic [7:0] CMD_VCOMH        = 8'hDB;
    localparam logic [7:0] CMD_RESUME_RAM   = 8'hA4;
    localparam logic [7:0] CMD_NORMAL       = 8'hA6;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] CMD_COL_ADDR     = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR    = 8'h22;

    localparam logic [4:0] INIT_LEN = 5'd25;
    localparam logic [4:0] SYNC_LEN = 5'd6;

    // Vertical addressing (20 01) matches the streamer's page-inner, column-outer order.
    localparam logic [199:0] INIT_SEQ = {
        CMD_DISPLAY_OFF, CMD_CLK_DIV, 8'h80, CMD_MUX_RATIO, 8'h1F, CMD_DISP_OFFSET, 8'h00,
        CMD_START_LINE, CMD_CHARGE_PUMP, 8'h14, CMD_ADDR_MODE, 8'h01, CMD_SEG_REMAP,
        CMD_COM_SCAN_DEC, CMD_COM_PINS, 8'h02, CMD_CONTRAST, 8'h8F, CMD_PRECHARGE, 8'hF1,
        CMD_VCOMH, 8'h40, CMD_RESUME_RAM, CMD_NORMAL, CMD_DISPLAY_ON};

    localparam logic [47:0] SYNC_SEQ = {CMD_COL_ADDR, 8'h00, 8'h7F, CMD_PAGE_ADDR, 8'h00, 8'h03};

    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        logic [199:0] s;
        s = INIT_SEQ << {idx, 3'b000};
        return s[199:192];
    endfunction

    function automatic logic [7:0] sync_byte(input logic [4:0] idx);
        logic [47:0] s;
        s = SYNC_SEQ << {idx, 3'b000};
        return s[47:40];
    endfunction

endpackage

// File: rtl/ssd1306_spi_driver_tx.sv
// spi_byte_tx: frames one mode-0 SPI byte (cs_n, dc, sck, mosi) and pulses o_done at the end of the cs_n gap.
module spi_byte_tx
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_dc,
    output logic       o_done,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_dc
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    tx_stage_t  r_stage, w_stage_nx;
    logic [7:0] r_div, r_sh;
    logic [2:0] r_bit;
    logic       r_sck, r_mosi, r_cs_n, r_dc;
    logic       w_tick;

    assign w_tick = r_div == DIV_LAST;
    assign o_done = r_stage == TX_GAP && w_tick;
    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_cs_n = r_cs_n;
    assign o_dc   = r_dc;

    always_comb begin
        w_stage_nx = r_stage;
        if (i_start)
            w_stage_nx = TX_LOW;
        else if (w_tick)
            case (r_stage)
                TX_LOW:  w_stage_nx = TX_HIGH;
                TX_HIGH: w_stage_nx = (r_bit == 3'd7) ? TX_HOLD : TX_LOW;
                TX_HOLD: w_stage_nx = r_bit[0] ? TX_GAP : TX_HOLD;
                TX_GAP:  w_stage_nx = TX_IDLE;
                default: w_stage_nx = r_stage;
            endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn)
            r_stage <= TX_IDLE;
        else
            r_stage <= w_stage_nx;
    end

    // The hold phase spans two dividers; r_bit (wrapped to 0) marks the first one.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_div  <= 8'd0;
            r_bit  <= 3'd0;
            r_sh   <= 8'd0;
            r_sck  <= 1'b0;
            r_mosi <= 1'b0;
            r_cs_n <= 1'b1;
            r_dc   <= 1'b0;
        end else if (i_start) begin
            r_div  <= 8'd0;
            r_bit  <= 3'd0;
            r_sh   <= {i_byte[6:0], 1'b0};
            r_sck  <= 1'b0;
            r_mosi <= i_byte[7];
            r_cs_n <= 1'b0;
            r_dc   <= i_dc;
        end else if (r_stage != TX_IDLE) begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            if (w_tick)
                case (r_stage)
                    TX_LOW:  r_sck <= 1'b1;
                    TX_HIGH: begin
                        r_sck <= 1'b0;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit != 3'd7) begin
                            r_mosi <= r_sh[7];
                            r_sh   <= r_sh << 1;
                        end
                    end
                    TX_HOLD: begin
                        r_bit  <= 3'd1;
                        r_cs_n <= r_bit[0];
                    end
                    default: r_sck <= 1'b0;
                endcase
        end
    end

endmodule

// File: rtl/ssd1306_spi_driver.sv
// ssd1306_spi_driver: panel reset, optional power-on init (SSD1306_INIT_SEQ_EN), then pixel/sync bytes over SPI.
// Without SSD1306_INIT_SEQ_EN the panel init is owned externally and S_INIT is never entered.
module ssd1306_spi_driver
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 1000
) (
    input  logic       clk_in,
    input  logic       resetn_in,
    input  logic [7:0] data_in,
    input  logic       write_stb_in,
    input  logic       sync_stb_in,
    output logic       ready_out,
    output logic       spi_sck_out,
    output logic       spi_mosi_out,
    output logic       spi_cs_n_out,
    output logic       spi_dc_out,
    output logic       oled_rst_n_out
);

    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [4:0]    r_idx, w_idx_nx;
    logic          r_ready, r_oled_rst_n;
    logic          w_start, w_dc, w_done, w_cnt_end;
    logic [7:0]    w_byte;

    assign w_cnt_end      = r_cnt == CNT_LAST;
    assign ready_out      = r_ready;
    assign oled_rst_n_out = r_oled_rst_n;

    // Each multi-byte state chains the next byte on the done pulse so cs_n gaps stay at CLK_DIV.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_start    = 1'b0;
        w_byte     = data_in;
        w_dc       = 1'b1;
        case (r_state)
            S_RST_LOW: begin
                w_cnt_nx = w_cnt_end ? '0 : r_cnt + 1'b1;
                if (w_cnt_end) w_state_nx = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                w_cnt_nx = w_cnt_end ? '0 : r_cnt + 1'b1;
                if (w_cnt_end) begin
`ifdef SSD1306_INIT_SEQ_EN
                    w_state_nx = S_INIT;
                    w_start    = 1'b1;
                    w_byte     = init_byte(5'd0);
                    w_dc       = 1'b0;
                    w_idx_nx   = 5'd1;
`else
                    w_state_nx = S_IDLE;
`endif
                end
            end
`ifdef SSD1306_INIT_SEQ_EN
            S_INIT: begin
                w_byte = init_byte(r_idx);
                w_dc   = 1'b0;
                if (w_done) begin
                    w_state_nx = (r_idx == INIT_LEN) ? S_IDLE : S_INIT;
                    w_start    = r_idx != INIT_LEN;
                    w_idx_nx   = r_idx + 5'd1;
                end
            end
`endif
            S_IDLE:
                if (write_stb_in) begin
                    w_state_nx = S_DATA;
                    w_start    = 1'b1;
                end else if (sync_stb_in) begin
                    w_state_nx = S_SYNC;
                    w_start    = 1'b1;
                    w_byte     = sync_byte(5'd0);
                    w_dc       = 1'b0;
                    w_idx_nx   = 5'd1;
                end
            S_DATA:
                if (w_done) w_state_nx = S_IDLE;
            S_SYNC: begin
                w_byte = sync_byte(r_idx);
                w_dc   = 1'b0;
                if (w_done) begin
                    w_state_nx = (r_idx == SYNC_LEN) ? S_IDLE : S_SYNC;
                    w_start    = r_idx != SYNC_LEN;
                    w_idx_nx   = r_idx + 5'd1;
                end
            end
            default: w_state_nx = S_RST_LOW;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in)
            r_state <= S_RST_LOW;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            r_cnt        <= '0;
            r_idx        <= 5'd0;
            r_ready      <= 1'b0;
            r_oled_rst_n <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nx;
            r_idx        <= w_idx_nx;
            r_ready      <= w_state_nx == S_IDLE;
            r_oled_rst_n <= w_state_nx != S_RST_LOW;
        end
    end

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .i_clk    (clk_in),
        .i_resetn (resetn_in),
        .i_start  (w_start),
        .i_byte   (w_byte),
        .i_dc     (w_dc),
        .o_done   (w_done),
        .o_sck    (spi_sck_out),
        .o_mosi   (spi_mosi_out),
        .o_cs_n   (spi_cs_n_out),
        .o_dc     (spi_dc_out)
    );

endmodule
